// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module  : uart_tx_fifo_if
// Brief   : Push-side and line-side signals of the buffered UART transmitter.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;
    logic                          tx;
    logic                          tx_busy;

    modport master (
        output wr_en, wr_data,
        input  full, empty, level, overflow, tx, tx_busy
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, level, overflow, tx, tx_busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : FIFO-buffered UART transmitter, configurable data/parity/stop.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 48_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_tx_fifo_if.slave   bus
);
    localparam int               c_div       = CLK_FREQ / BAUD_RATE;
    localparam int               c_cnt_w     = $clog2(c_div);
    localparam int               c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int               c_lvl_w     = c_ptr_w + 1;
    localparam logic [7:0]       c_mask      = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]       c_last_data = 3'(DATA_BITS - 1);
    localparam logic [2:0]       c_last_stop = 3'(STOP_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_div - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_lvl_w-1:0]  r_level;
    logic                r_ovf;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2:0]          r_idx;
    logic [7:0]          r_shift;
    logic                r_par;
    logic                r_tx;

    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [2:0]          w_idx_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_par_nxt;
    logic                w_tx_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic                w_bit_done;
    logic [7:0]          w_head;

    assign w_full     = (r_level == c_lvl_w'(FIFO_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_push     = bus.wr_en && !w_full;
    assign w_bit_done = (r_cnt == c_cnt_last);
    // Bits above DATA_BITS-1 never reach the line or the parity.
    assign w_head     = r_mem[r_rd_ptr] & c_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_shift_nxt = w_head;
                    w_par_nxt   = (PARITY == 1) ? ~^w_head : ^w_head;
                    w_idx_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_last_data) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
            S_PAR: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_last_stop) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Line level is registered from the upcoming state so tx never glitches.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            S_PAR:   w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_ovf <= bus.wr_en && w_full;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_ovf;
    assign bus.tx       = r_tx;
    assign bus.tx_busy  = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire
